// File: rtl/lab_mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with KMP failure transitions,
// optional overlapping matches, clock enable and a saturating match counter.
module lab_mealy_seq_detector #(
  parameter int unsigned           PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]    PATTERN = 4'b1011,
  parameter bit                    OVERLAP = 1'b1,
  parameter int unsigned           CNT_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       x,
  input  logic                       en,
  output logic                       z,
  output logic [$clog2(PAT_LEN)-1:0] state_o,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned SW = $clog2(PAT_LEN);
  localparam int          PL = int'(PAT_LEN);

  // Pattern bit i in arrival order (i = 0 is the first bit received).
  function automatic int pat_bit(input int i);
    logic [15:0] p;
    p = 16'(PATTERN);
    if (i >= 0 && i < PL) return int'(p[4'(PL - 1 - i)]);
    return 0;
  endfunction

  function automatic int full_border();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j < 16; j++) begin
      if (j < PL) begin
        ok = 1'b1;
        for (int t = 0; t < 16; t++) begin
          if (t < j) begin
            if (pat_bit(t) != pat_bit(PL - j + t)) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Next matched-prefix length from state k on input bit b.
  function automatic int next_state(input int k, input int b);
    int s [17];
    int best;
    bit ok;
    for (int i = 0; i < 17; i++) s[i] = (i < k) ? pat_bit(i) : 0;
    s[k] = b;
    if (b == pat_bit(k)) begin
      if (k < PL - 1) return k + 1;
      return OVERLAP ? full_border() : 0;
    end
    best = 0;
    for (int j = 1; j < 17; j++) begin
      if (j <= k) begin
        ok = 1'b1;
        for (int t = 0; t < 16; t++) begin
          if (t < j) begin
            if (pat_bit(t) != s[k + 1 - j + t]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_nxt [PAT_LEN][2];
  logic             w_z;

  // Constant transition table, folded at elaboration.
  for (genvar k = 0; k < PL; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      assign w_nxt[k][b] = SW'(next_state(k, b));
    end
  end

  assign w_z = reset & en & (r_state == SW'(PL - 1)) & (x == PATTERN[0]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else if (en) begin
      r_state <= w_nxt[r_state][x];
      if (w_z && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign z         = w_z;
  assign state_o   = r_state;
  assign match_cnt = r_cnt;

endmodule
